// File: rtl/intr_ctrl.sv
// Interrupt request controller: latches N_SRC sources as pending, masks them, and runs the
// intr/inta/eoi handshake with the CPU. Define INTC_EDGE_DETECT_EN for edge-triggered sources.
module intr_ctrl #(
  parameter int N_SRC = 8,
  parameter int ID_W  = 3
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_wdata,
  input  logic             inta,
  input  logic             eoi,
  output logic             intr,
  output logic [ID_W-1:0]  vec_id,
  output logic [N_SRC-1:0] pending,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] req_det;
  logic [N_SRC-1:0] unmasked;
  logic [N_SRC-1:0] clr_vec;
  logic [ID_W-1:0]  vec_q, vec_d;
  logic [ID_W-1:0]  sel;
  logic             sel_vld;

`ifdef INTC_EDGE_DETECT_EN
  logic [N_SRC-1:0] src_q;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge Clk) begin
    if (Clr) src_q <= '0;
    else     src_q <= irq_src;
  end

  assign req_det = irq_src & ~src_q;
`else
  assign req_det = irq_src;
`endif

  assign unmasked = pend_q & ~mask_q;

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (unmasked[i]) begin
        sel     = ID_W'(i);
        sel_vld = 1'b1;
      end
    end
  end

  // NOTE: every output of this block is given a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    clr_vec = '0;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          vec_d   = sel;
          state_d = REQ;
        end
      end
      REQ: begin
        if (inta) begin
          clr_vec[vec_q] = 1'b1;
          state_d        = SERV;
        end
      end
      SERV: begin
        if (eoi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A capture on the same edge as the acknowledge clear wins.
  assign pend_d = (pend_q & ~clr_vec) | req_det;

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state_q <= IDLE;
      pend_q  <= '0;
      mask_q  <= '1;
      vec_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      vec_q   <= vec_d;
      if (mask_we) mask_q <= mask_wdata;
    end
  end

  assign intr    = (state_q == REQ);
  assign busy    = (state_q == SERV);
  assign vec_id  = vec_q;
  assign pending = pend_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Self-checking bench for intr_ctrl: directed handshake scenarios followed by a randomized run,
// with a reference model feeding an expected-vector queue drained by an independent monitor.
module tb_intr_ctrl;

  localparam int N = 8;
  localparam int W = 3;

  logic         Clk = 1'b0;
  logic         Clr = 1'b1;
  logic [N-1:0] irq_src = '0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_wdata = '0;
  logic         inta = 1'b0;
  logic         eoi = 1'b0;
  logic         intr;
  logic [W-1:0] vec_id;
  logic [N-1:0] pending;
  logic         busy;

  int checks   = 0;
  int failures = 0;

  intr_ctrl #(.N_SRC(N), .ID_W(W)) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .irq_src   (irq_src),
    .mask_we   (mask_we),
    .mask_wdata(mask_wdata),
    .inta      (inta),
    .eoi       (eoi),
    .intr      (intr),
    .vec_id    (vec_id),
    .pending   (pending),
    .busy      (busy)
  );

  always #50 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Reference model: pending set, mask, and the controller's handshake phase.
  // phase 0 = waiting for work, 1 = requesting the CPU, 2 = CPU is servicing m_id.
  logic [N-1:0] m_pend  = '0;
  logic [N-1:0] m_mask  = '1;
  logic [N-1:0] m_srcq  = '0;
  int           m_phase = 0;
  int           m_id    = 0;
  int           exp_q[$];

  function automatic int lowest(input logic [N-1:0] v);
    logic [N-1:0] iso;
    iso = v & (~v + 1'b1);
    return $clog2(iso);
  endfunction

  always @(posedge Clk) begin : model
    logic [N-1:0] caught;
    logic [N-1:0] cleared;
    int           pick;
    if (Clr) begin
      m_pend  <= '0;
      m_mask  <= '1;
      m_srcq  <= '0;
      m_phase <= 0;
      m_id    <= 0;
      exp_q.delete();
    end else begin
`ifdef INTC_EDGE_DETECT_EN
      caught = irq_src & ~m_srcq;
`else
      caught = irq_src;
`endif
      cleared = '0;
      if (m_phase == 0 && (m_pend & ~m_mask) != '0) begin
        pick = lowest(m_pend & ~m_mask);
        m_id    <= pick;
        m_phase <= 1;
        exp_q.push_back(pick);
      end else if (m_phase == 1 && inta) begin
        cleared[m_id] = 1'b1;
        m_phase <= 2;
      end else if (m_phase == 2 && eoi) begin
        m_phase <= 0;
      end
      m_pend <= (m_pend & ~cleared) | caught;
      if (mask_we) m_mask <= mask_wdata;
      m_srcq <= irq_src;
    end
  end

  // Monitor: every cycle compare handshake outputs; on each new request pop the expected id.
  logic prev_intr = 1'b0;
  always @(negedge Clk) begin : monitor
    int e;
    check("intr", {31'd0, intr}, {31'd0, m_phase == 1});
    check("busy", {31'd0, busy}, {31'd0, m_phase == 2});
    check("pending", 32'(pending), 32'(m_pend));
    if (intr && !prev_intr) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL vec_id: request raised with vec_id=%0d but none expected (t=%0t)", vec_id, $time);
      end else begin
        e = exp_q.pop_front();
        check("vec_id", 32'(vec_id), 32'(e));
      end
    end
    prev_intr <= intr;
  end

  initial begin
    #(100 * 20000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int services;
    @(negedge Clk);
    Clr = 1'b0;
    check("rst_intr", {31'd0, intr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_vec", 32'(vec_id), 32'd0);

    // 1: single source, full handshake
    mask_we = 1'b1; mask_wdata = '0; tick(); mask_we = 1'b0;
    irq_src = 8'h08; tick(); irq_src = '0;
    check("t1_pend", 32'(pending), 32'h08);
    check("t1_intr_early", {31'd0, intr}, 32'd0);
    tick();
    check("t1_intr", {31'd0, intr}, 32'd1);
    check("t1_vec", 32'(vec_id), 32'd3);
    inta = 1'b1; tick(); inta = 1'b0;
    check("t1_ack_intr", {31'd0, intr}, 32'd0);
    check("t1_ack_busy", {31'd0, busy}, 32'd1);
    check("t1_ack_pend", 32'(pending), 32'd0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("t1_eoi_busy", {31'd0, busy}, 32'd0);
    tick();
    check("t1_eoi_intr", {31'd0, intr}, 32'd0);

    // 2: simultaneous captures serviced in index order
    irq_src = 8'h22; tick(); irq_src = '0; tick();
    check("t2_first", 32'(vec_id), 32'd1);
    inta = 1'b1; tick(); inta = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    check("t2_second_intr", {31'd0, intr}, 32'd1);
    check("t2_second_vec", 32'(vec_id), 32'd5);
    inta = 1'b1; tick(); inta = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0; tick();

    // 3: masked source stays pending until unmasked; selection uses the old mask on the write edge
    mask_we = 1'b1; mask_wdata = 8'h04; tick(); mask_we = 1'b0;
    irq_src = 8'h04; tick(); irq_src = '0; tick();
    check("t3_pend", 32'(pending), 32'h04);
    check("t3_masked_intr", {31'd0, intr}, 32'd0);
    mask_we = 1'b1; mask_wdata = 8'h00; tick(); mask_we = 1'b0;
    check("t3_write_edge_intr", {31'd0, intr}, 32'd0);
    tick();
    check("t3_intr", {31'd0, intr}, 32'd1);
    check("t3_vec", 32'(vec_id), 32'd2);
    inta = 1'b1; tick(); inta = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0; tick();

    // 4: higher-priority arrival during REQ does not preempt
    irq_src = 8'h10; tick(); irq_src = '0; tick();
    irq_src = 8'h01; tick(); irq_src = '0;
    check("t4_hold_vec", 32'(vec_id), 32'd4);
    tick();
    check("t4_hold_vec2", 32'(vec_id), 32'd4);
    inta = 1'b1; tick(); inta = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0; tick();
    check("t4_next_intr", {31'd0, intr}, 32'd1);
    check("t4_next_vec", 32'(vec_id), 32'd0);
    inta = 1'b1; tick(); inta = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0; tick();

    // 5: stray eoi/inta ignored; reset mid-request
    eoi = 1'b1; tick(); eoi = 1'b0;
    check("t5_idle_eoi", {30'd0, busy, intr}, 32'd0);
    irq_src = 8'h08; tick(); irq_src = '0; tick();
    inta = 1'b1; tick(); inta = 1'b0;
    inta = 1'b1; tick(); inta = 1'b0;
    check("t5_serv_inta_busy", {31'd0, busy}, 32'd1);
    check("t5_serv_inta_pend", 32'(pending), 32'd0);
    eoi = 1'b1; tick(); eoi = 1'b0;
    irq_src = 8'h08; tick(); irq_src = '0; tick();
    check("t5_req_before_clr", {31'd0, intr}, 32'd1);
    Clr = 1'b1; tick(); Clr = 1'b0;
    check("t5_clr_intr", {31'd0, intr}, 32'd0);
    check("t5_clr_pend", 32'(pending), 32'd0);
    irq_src = 8'h02; tick(); irq_src = '0; tick(); tick();
    check("t5_mask_ff_pend", 32'(pending), 32'h02);
    check("t5_mask_ff_intr", {31'd0, intr}, 32'd0);
    mask_we = 1'b1; mask_wdata = '0; tick(); mask_we = 1'b0; tick();
    check("t5_unmask_vec", 32'(vec_id), 32'd1);
    inta = 1'b1; tick(); inta = 1'b0;
    eoi = 1'b1; tick(); eoi = 1'b0; tick();

    // 6: line held high for 10 cycles with a prompt CPU
    services = 0;
    irq_src = 8'h40;
    for (int c = 0; c < 24; c++) begin
      if (c == 10) irq_src = '0;
      inta = intr;
      eoi  = busy;
      if (intr) services++;
      tick();
    end
    inta = 1'b0; eoi = 1'b0;
`ifdef INTC_EDGE_DETECT_EN
    check("t6_services", 32'(services), 32'd1);
`else
    check("t6_rerequest", {31'd0, services >= 2}, 32'd1);
`endif

    // Randomized run; the monitor and model do the checking.
    for (int c = 0; c < 3000; c++) begin
      irq_src    = N'($urandom & $urandom & $urandom);
      mask_we    = ($urandom_range(0, 9) == 0);
      mask_wdata = N'($urandom & $urandom);
      inta       = intr ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      eoi        = ($urandom_range(0, 3) == 0);
      Clr        = ($urandom_range(0, 299) == 0);
      tick();
    end
    irq_src = '0; mask_we = 1'b0; inta = 1'b0; eoi = 1'b0; Clr = 1'b0;
    tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
